data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Parametrised, multi-cycle data memory controller that replaces the single-cycle word-only data memory path of the CPU. It accepts one load/store request at a time over a valid/ready handshake and supports byte, halfword and word accesses with sign/zero extension. It delivers a one-cycle response pulse after a configurable latency and flags misaligned, unsupported or out-of-range accesses. It sits between the ALU address/rs2 outputs and the write-back mux; the core stalls while a request is outstanding.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 4.
- LATENCY, 1: clock edges from accept edge to response; integer from 1 to 15.
- CLEAR_ON_RESET, 1: 1 means reset zeroes every memory word; 0 means memory contents survive reset.

Ports (reset is asynchronous, active-high; clock is clk):
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept this cycle
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 size/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_error  out  1  qualified by rsp_valid
- busy  out  1  request accepted and not yet responded

## Operation
- States are IDLE, WAIT and RESP. A 4-bit down-counter cnt is used in WAIT.
- req_ready is 1 in IDLE and in RESP, and 0 in WAIT or while reset is high.
- Accept occurs on any edge where req_valid and req_ready are both 1.
  - On accept, req_write, req_funct3, req_addr and req_wdata are latched.
  - Next state is WAIT with cnt = LATENCY-1.
- In WAIT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, go to RESP on the next edge. That same edge commits a store or captures load data into rsp_rdata/rsp_error.
- In RESP, rsp_valid = 1. On the next edge:
  - Go to WAIT if a new request is accepted.
  - Otherwise go to IDLE.
- busy = 1 in WAIT, 0 otherwise.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. The byte lane is addr[1:0].
- Load funct3 codes:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the halfword at lane addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the halfword at lane addr[1].
- Store funct3 codes:
  - 000 SB: writes wdata[7:0] to lane addr[1:0].
  - 001 SH: writes wdata[15:0] to lanes 2*addr[1] and 2*addr[1]+1.
  - 010 SW: writes the full word.
  - Bytes outside the written lanes are unchanged.
- Error conditions; rsp_error = 1 if any holds:
  - An unsupported funct3: loads 011, 110 or 111; stores 011 or higher.
  - A halfword access with addr[0] = 1.
  - A word access with addr[1:0] != 0.
  - Any addr bit above log2(DEPTH_WORDS)+1 is set (out of range).
- On error: no memory write, rsp_rdata = 0.
- Error precedence does not matter; only the single error bit is reported.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_error 0, busy 0, cnt 0.
- If CLEAR_ON_RESET = 1, all words are set to 0.
- Reset asserted mid-operation (WAIT or RESP) aborts the request: a pending store is not committed and no response is issued.
- Latency: for a request accepted at edge E0, rsp_valid is high for exactly the one cycle following edge E0+LATENCY.
- Throughput: back-to-back requests take one every LATENCY+1 cycles, because the next request is accepted during RESP.
- Read-after-write: a load accepted in the RESP cycle of a store observes the stored data.
- rsp_rdata and rsp_error hold their values after RESP until the next response. They are meaningful only while rsp_valid = 1.
- The request inputs may change freely after the accept edge; only the latched copies are used.
- rsp_valid has no back-pressure; the consumer must take the response in the RESP cycle.

## Test plan
- Reset, then SW 0x12345678 to address 0x10 with LATENCY=1:
  - rsp_valid is high in the cycle after edge E0+1, with rsp_error = 0.
  - LW from 0x10 then returns 0x12345678.
- SB 0xAB to 0x11, then LB from 0x11 and LBU from 0x11:
  - LB returns 0xFFFFFFAB and LBU returns 0x000000AB.
  - LW from 0x10 returns 0x1234AB78.
- SH 0x8001 to 0x22, then LH and LHU from 0x22:
  - LH returns 0xFFFF8001 and LHU returns 0x00008001.
- Misaligned and unsupported accesses:
  - LW from 0x13, SH to 0x21, and LB with funct3 011 each give rsp_error = 1 and rsp_rdata = 0.
  - LW from 0x20 afterwards shows memory unchanged.
- DEPTH_WORDS=256, LW from 0x400: rsp_error = 1.
- LATENCY=4, back-to-back requests with req_valid held high:
  - Accepts occur every 5 cycles.
  - busy is high for 4 cycles per request.
  - req_ready is 0 throughout WAIT.
- SW 0xDEADBEEF to 0x40, with reset asserted while in WAIT:
  - No rsp_valid pulse is issued.
  - LW from 0x40 after reset returns 0x00000000 (CLEAR_ON_RESET=1).

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Multi-cycle data memory controller: byte/half/word loads and stores
// with sign/zero extension, configurable latency and error reporting.
module data_memory_ctrl #(
  parameter int DEPTH_WORDS    = 256,
  parameter int LATENCY        = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;

  logic        l_write;
  logic [2:0]  l_f3;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        we;

  assign req_ready = (state != WAIT) && !reset;
  assign accept    = req_valid && req_ready;
  assign commit    = (state == WAIT) && (cnt == 4'd0);
  assign busy      = (state == WAIT);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = WAIT;
          cnt_nx   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      RESP: begin
        if (accept) begin
          state_nx = WAIT;
          cnt_nx   = CNT_INIT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_write <= 1'b0;
      l_f3    <= 3'd0;
      l_addr  <= 32'd0;
      l_wdata <= 32'd0;
    end else if (accept) begin
      l_write <= req_write;
      l_f3    <= req_funct3;
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
    end
  end

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          is_b;
  logic          is_h;
  logic          is_w;
  logic          f3_err;
  logic          align_err;
  logic          range_err;
  logic          err;

  assign idx  = l_addr[AW+1:2];
  assign lane = l_addr[1:0];
  assign is_b = (l_f3[1:0] == 2'b00);
  assign is_h = (l_f3[1:0] == 2'b01);
  assign is_w = (l_f3 == 3'b010);

  assign f3_err = l_write ? (l_f3 > 3'd2)
                          : (l_f3 == 3'b011) || (l_f3[2:1] == 2'b11);
  assign align_err = (is_h && lane[0]) || (is_w && lane != 2'd0);
  // Any address bit above the word index makes the access out of range.
  assign range_err = (l_addr >> (AW + 2)) != 32'd0;
  assign err       = f3_err || align_err || range_err;

  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        sx;
  logic [31:0] ld;

  assign rword = mem[idx];
  assign rbyte = 8'(rword >> {lane, 3'b000});
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];
  assign sx    = !l_f3[2];

  always_comb begin
    ld = {{24{sx & rbyte[7]}}, rbyte};
    if (is_w)      ld = rword;
    else if (is_h) ld = {{16{sx & rhalf[15]}}, rhalf};
  end

  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] wword;

  always_comb begin
    be = 4'b0001 << lane;
    wd = {4{l_wdata[7:0]}};
    if (is_w) begin
      be = 4'b1111;
      wd = l_wdata;
    end else if (is_h) begin
      be = lane[1] ? 4'b1100 : 4'b0011;
      wd = {2{l_wdata[15:0]}};
    end
    for (int i = 0; i < 4; i++)
      wword[8*i +: 8] = be[i] ? wd[8*i +: 8] : rword[8*i +: 8];
  end

  assign we = commit && l_write && !err;

  if (CLEAR_ON_RESET) begin : g_clr
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
      end else if (we) begin
        mem[idx] <= wword;
      end
    end
  end else begin : g_keep
    always_ff @(posedge clk) begin
      if (we && !reset) mem[idx] <= wword;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else if (commit) begin
      rsp_error <= err;
      rsp_rdata <= (l_write || err) ? 32'd0 : ld;
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: byte-array reference model, directed
// literal checks and randomized traffic compared every cycle.
module tb_data_memory_ctrl;

  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;

  data_memory_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;

  // reference model state
  byte unsigned mem_m [DEPTH*4];
  bit           pending;
  bit           in_resp;
  int           left;
  logic         m_w;
  logic [2:0]   m_f3;
  logic [31:0]  m_a;
  logic [31:0]  m_d;
  logic [31:0]  exp_rdata;
  logic         exp_err;

  bit meas;
  int acc_t[$];
  int busy_n;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int size_of(logic w, logic [2:0] f3);
    int sz;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    if (w && f3 > 3'd2) sz = 0;
    return sz;
  endfunction

  task automatic perform();
    int sz;
    longint v;
    sz = size_of(m_w, m_f3);
    exp_err = 1'b0;
    if (sz == 0) exp_err = 1'b1;
    else if ((m_a % sz) != 0) exp_err = 1'b1;
    else if (m_a >= 32'(DEPTH*4)) exp_err = 1'b1;
    exp_rdata = 32'd0;
    if (exp_err) return;
    if (m_w) begin
      for (int i = 0; i < sz; i++)
        mem_m[m_a + i] = 8'(m_d >> (8*i));
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++)
        v = v + (longint'(mem_m[m_a + i]) << (8*i));
      if (!m_f3[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1)))
        v = v - (longint'(1) << (8*sz));
      exp_rdata = 32'(v);
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit nr;
    acc = req_valid && !pending && !reset;
    nr = 1'b0;
    if (reset) return;
    if (pending) begin
      left--;
      if (left == 0) begin
        perform();
        pending = 1'b0;
        nr = 1'b1;
      end
    end
    if (acc) begin
      pending = 1'b1;
      left = LAT;
      m_w = req_write;
      m_f3 = req_funct3;
      m_a = req_addr;
      m_d = req_wdata;
    end
    in_resp = nr;
  endtask

  task automatic check_outputs();
    chk("req_ready", req_ready, (!pending && !reset));
    chk("busy", busy, pending);
    chk("rsp_valid", rsp_valid, in_resp);
    if (in_resp) begin
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_error", rsp_error, exp_err);
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input logic v, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
    check_outputs();
    req_valid = v;
    req_write = w;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = d;
    if (meas) begin
      if (req_valid && req_ready) acc_t.push_back(cyc);
      if (busy) busy_n++;
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic junk_step();
    step(1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    pending = 1'b0;
    in_resp = 1'b0;
    foreach (mem_m[i]) mem_m[i] = 8'd0;
    #1;
    chk("rst_ready", req_ready, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_valid", rsp_valid, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_error", rsp_error, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pending || in_resp) && n < 40) begin
      junk_step();
      n++;
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] lit_d, input logic lit_e);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      acc = !pending && !reset;
      step(1'b1, w, f3, a, d);
      n++;
    end
    n = 0;
    while (!in_resp && n < 40) begin
      junk_step();
      n++;
    end
    if (!in_resp) begin
      vectors++;
      errs++;
      $display("FAIL resp_timeout: addr %h no response", a);
    end else begin
      chk("lit_valid", rsp_valid, 32'd1);
      chk("lit_rdata", rsp_rdata, lit_d);
      chk("lit_error", rsp_error, lit_e);
    end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    pending = 1'b0;
    in_resp = 1'b0;
    meas = 1'b0;
    busy_n = 0;
    #1;
    apply_reset();
    @(negedge clk);

    do_req(1, 3'b010, 32'h10, 32'h12345678, 32'h0, 1'b0);
    do_req(0, 3'b010, 32'h10, 32'h0, 32'h12345678, 1'b0);
    do_req(1, 3'b000, 32'h11, 32'h000000AB, 32'h0, 1'b0);
    do_req(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAB, 1'b0);
    do_req(0, 3'b100, 32'h11, 32'h0, 32'h000000AB, 1'b0);
    do_req(0, 3'b010, 32'h10, 32'h0, 32'h1234AB78, 1'b0);
    do_req(1, 3'b001, 32'h22, 32'h00008001, 32'h0, 1'b0);
    do_req(0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
    do_req(0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0);
    do_req(0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1);
    do_req(1, 3'b001, 32'h21, 32'h5555, 32'h0, 1'b1);
    do_req(0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    do_req(0, 3'b010, 32'h20, 32'h0, 32'h80010000, 1'b0);
    do_req(0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
    do_req(1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 1'b1);
    do_req(0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0);

    // back-to-back loads with valid held high
    wait_idle();
    meas = 1'b1;
    for (int i = 0; i < 3*(LAT+1); i++)
      step(1'b1, 1'b0, 3'b010, 32'(4*i), 32'd0);
    meas = 1'b0;
    chk("accept_count", acc_t.size(), 32'd3);
    if (acc_t.size() >= 3) begin
      chk("accept_gap1", acc_t[1] - acc_t[0], LAT + 1);
      chk("accept_gap2", acc_t[2] - acc_t[1], LAT + 1);
    end
    chk("busy_cycles", busy_n, 3*LAT);

    // reset while a store is waiting
    wait_idle();
    step(1'b1, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
    junk_step();
    chk("busy_before_rst", busy, 32'd1);
    #2;
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < LAT + 2; i++) junk_step();
    do_req(0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 63));
      step(($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom),
           a, $urandom);
    end
    wait_idle();
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
